// File: rtl/grf_wb_queue_if.sv
// grf_wb_queue_if
// Bundles every non-clock/reset signal of the GRF writeback queue.
//   Producer side : in_valid, in_ready, in_wa, in_wd, in_pc
//   GRF write port: wb_hold, WE, WA, WD, PC
//   Forwarding    : qa1/qa2 query addresses, hit1/hit2 and fd1/fd2 results
// Modport slave is the queue itself; modport master is whoever drives the
// pipeline/GRF side (the writeback stage plus GRF, or a testbench).
interface grf_wb_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_wa;
   logic [31:0] in_wd;
   logic [31:0] in_pc;
   logic        wb_hold;
   logic        WE;
   logic [4:0]  WA;
   logic [31:0] WD;
   logic [31:0] PC;
   logic [4:0]  qa1;
   logic [4:0]  qa2;
   logic        hit1;
   logic        hit2;
   logic [31:0] fd1;
   logic [31:0] fd2;

   modport slave (
      input  in_valid, in_wa, in_wd, in_pc, wb_hold, qa1, qa2,
      output in_ready, WE, WA, WD, PC, hit1, hit2, fd1, fd2
   );

   modport master (
      output in_valid, in_wa, in_wd, in_pc, wb_hold, qa1, qa2,
      input  in_ready, WE, WA, WD, PC, hit1, hit2, fd1, fd2
   );
endinterface

// File: rtl/grf_wb_queue.sv
// grf_wb_queue
// Buffered writeback queue in front of the general register file write port.
// Requests {wa, wd, pc} are accepted from the pipeline into a circular buffer
// and issued to the GRF one per cycle in strict FIFO order whenever the write
// port is not held. Two combinational lookup ports let readers see the newest
// value still pending for a register.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   Reset - synchronous active-high reset, discards all pending entries
//   bus   - grf_wb_queue_if.slave (producer handshake, GRF write port,
//           forwarding queries and results)
module grf_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            Reset,
   grf_wb_queue_if.slave   bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [4:0]    r_entryWa [DEPTH];
   logic [31:0]   r_entryWd [DEPTH];
   logic [31:0]   r_entryPc [DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;

   logic          w_ready;
   logic          w_notEmpty;
   logic          w_doEnq;
   logic          w_doDeq;
   logic          w_hit1;
   logic          w_hit2;
   logic [31:0]   w_fd1;
   logic [31:0]   w_fd2;

   // Readiness deliberately ignores a same-cycle dequeue so that in_ready
   // never depends on wb_hold; a full queue always refuses for one cycle.
   assign w_ready    = !Reset && (r_count < CW'(DEPTH));
   assign w_notEmpty = (r_count != '0);
   assign w_doEnq    = bus.in_valid && w_ready;
   assign w_doDeq    = w_notEmpty && !bus.wb_hold;

   // The head entry is presented directly; an empty queue shows zeros so the
   // GRF trace never sees stale buffer contents.
   assign bus.in_ready = w_ready;
   assign bus.WE       = w_notEmpty;
   assign bus.WA       = w_notEmpty ? r_entryWa[r_rdPtr] : 5'd0;
   assign bus.WD       = w_notEmpty ? r_entryWd[r_rdPtr] : 32'd0;
   assign bus.PC       = w_notEmpty ? r_entryPc[r_rdPtr] : 32'd0;
   assign bus.hit1     = w_hit1;
   assign bus.hit2     = w_hit2;
   assign bus.fd1      = w_fd1;
   assign bus.fd2      = w_fd2;

   // Entry storage has no reset: validity is defined solely by the pointers
   // and count, so stale contents are never observable.
   always_ff @(posedge clk) begin
      if (w_doEnq) begin
         r_entryWa[r_wrPtr] <= bus.in_wa;
         r_entryWd[r_wrPtr] <= bus.in_wd;
         r_entryPc[r_wrPtr] <= bus.in_pc;
      end
   end

   // Pointer and occupancy bookkeeping. Reset wins over any same-edge
   // enqueue or dequeue so pending writes are dropped without being issued.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doEnq) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_doDeq) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         case ({w_doEnq, w_doDeq})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Forwarding lookup walks the valid entries from oldest (rp) to newest,
   // letting each later match overwrite the earlier one so the result is the
   // entry closest to wp. Register 0 never hits since the GRF discards it.
   always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
      w_fd1  = 32'd0;
      w_fd2  = 32'd0;
      for (int k = 0; k < DEPTH; k++) begin
         logic [PW-1:0] idx;
         idx = r_rdPtr + PW'(k);
         if (CW'(k) < r_count) begin
            if ((bus.qa1 != 5'd0) && (r_entryWa[idx] == bus.qa1)) begin
               w_hit1 = 1'b1;
               w_fd1  = r_entryWd[idx];
            end
            if ((bus.qa2 != 5'd0) && (r_entryWa[idx] == bus.qa2)) begin
               w_hit2 = 1'b1;
               w_fd2  = r_entryWd[idx];
            end
         end
      end
   end

endmodule
